// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
//   Producer-side end of the register file write port. Collects writeback
//   requests from the ALU and load paths into a small in-order FIFO and
//   drives the register file's single write port one entry per cycle.
//   Also provides a forwarding lookup and a pending-write mask, so the read
//   side can see values that have not been committed yet.
//
// Ports
//   clock, reset_n          clock, asynchronous active-low reset
//   alu_valid/ready/rd/data ALU writeback request channel
//   mem_valid/ready/rd/data load writeback request channel
//   wr_en/wr_select/wr_data registered register-file write port
//   fwd_select              register being read by the read side
//   fwd_hit/fwd_data        youngest pending value for fwd_select
//   pending                 one bit per register with a queued or in-flight write
//   count                   current FIFO occupancy
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             wr_en,
  output logic [4:0]       wr_select,
  output logic [31:0]      wr_data,
  input  logic [4:0]       fwd_select,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic [31:0]      pending,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] DEPTH_M1_C = (PTR_W+1)'(DEPTH - 1);

  logic [4:0]       rd_mem_r   [DEPTH];
  logic [31:0]      data_mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             wr_en_r;
  logic [4:0]       wr_select_r;
  logic [31:0]      wr_data_r;

  logic             alu_ready_s;
  logic             mem_ready_s;
  logic             enq_alu_s;
  logic             enq_mem_s;
  logic             pop_s;
  logic [PTR_W-1:0] mem_slot_s;
  logic [PTR_W-1:0] idx_s;
  logic             fwd_hit_s;
  logic [31:0]      fwd_data_s;
  logic [31:0]      pending_s;

  // Ready depends only on registered occupancy. A slot freed by this edge's
  // pop is not reused, so the load path is only admitted at DEPTH-1 when the
  // ALU is not claiming the last free slot.
  always_comb begin
    alu_ready_s = (count_r < DEPTH_C);
    mem_ready_s = (count_r < DEPTH_M1_C) || ((count_r == DEPTH_M1_C) && !alu_valid);
    // x0 requests complete their handshake but never occupy a slot
    enq_alu_s   = alu_valid && alu_ready_s && (alu_rd != 5'd0);
    enq_mem_s   = mem_valid && mem_ready_s && (mem_rd != 5'd0);
    pop_s       = (count_r != '0);
    // the load entry lands behind the ALU entry when both are enqueued
    mem_slot_s  = enq_alu_s ? (tail_r + PTR_W'(1)) : tail_r;
  end

  // FIFO storage, pointers, occupancy and the registered write port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      wr_en_r     <= 1'b0;
      wr_select_r <= 5'd0;
      wr_data_r   <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= 32'd0;
      end
    end else begin
      if (pop_s) begin
        wr_en_r     <= 1'b1;
        wr_select_r <= rd_mem_r[head_r];
        wr_data_r   <= data_mem_r[head_r];
        head_r      <= head_r + PTR_W'(1);
      end else begin
        // select/data hold their last values while idle
        wr_en_r     <= 1'b0;
      end
      if (enq_alu_s) begin
        rd_mem_r[tail_r]   <= alu_rd;
        data_mem_r[tail_r] <= alu_data;
      end
      if (enq_mem_s) begin
        rd_mem_r[mem_slot_s]   <= mem_rd;
        data_mem_r[mem_slot_s] <= mem_data;
      end
      tail_r  <= tail_r + PTR_W'(enq_alu_s) + PTR_W'(enq_mem_s);
      count_r <= count_r - (PTR_W+1)'(pop_s) + (PTR_W+1)'(enq_alu_s) + (PTR_W+1)'(enq_mem_s);
    end
  end

  // Forwarding and pending mask. Lowest priority first: the output stage, then
  // FIFO entries oldest to youngest, so the youngest match overwrites older ones.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'd0;
    pending_s  = 32'd0;
    idx_s      = head_r;
    if (wr_en_r) begin
      pending_s[wr_select_r] = 1'b1;
      if (wr_select_r == fwd_select) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = wr_data_r;
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end else begin
      pending_s = pending_s;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_r + PTR_W'(i);
      if ((PTR_W+1)'(i) < count_r) begin
        pending_s[rd_mem_r[idx_s]] = 1'b1;
        if (rd_mem_r[idx_s] == fwd_select) begin
          fwd_hit_s  = 1'b1;
          fwd_data_s = data_mem_r[idx_s];
        end else begin
          fwd_hit_s  = fwd_hit_s;
        end
      end else begin
        pending_s = pending_s;
      end
    end
    pending_s[0] = 1'b0;
    // x0 is hard-wired, nothing is ever forwarded for it
    if (fwd_select == 5'd0) begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = 32'd0;
    end else begin
      fwd_hit_s  = fwd_hit_s;
    end
  end

  assign alu_ready = alu_ready_s;
  assign mem_ready = mem_ready_s;
  assign wr_en     = wr_en_r;
  assign wr_select = wr_select_r;
  assign wr_data   = wr_data_r;
  assign fwd_hit   = fwd_hit_s;
  assign fwd_data  = fwd_data_s;
  assign pending   = pending_s;
  assign count     = count_r;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           alu_valid;
  logic           alu_ready;
  logic [4:0]     alu_rd;
  logic [31:0]    alu_data;
  logic           mem_valid;
  logic           mem_ready;
  logic [4:0]     mem_rd;
  logic [31:0]    mem_data;
  logic           wr_en;
  logic [4:0]     wr_select;
  logic [31:0]    wr_data;
  logic [4:0]     fwd_select;
  logic           fwd_hit;
  logic [31:0]    fwd_data;
  logic [31:0]    pending;
  logic [PTR_W:0] count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wr_en(wr_en), .wr_select(wr_select), .wr_data(wr_data),
    .fwd_select(fwd_select), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pending(pending), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // scoreboard: accepted writes in acceptance order, popped when the DUT should emit them
  ent_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        exp_wr_en;
  logic [4:0]  exp_sel;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = 32'd0;
    foreach (sb_q[i]) p[sb_q[i].rd] = 1'b1;
    if (exp_wr_en) p[exp_sel] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_fwd(input logic [4:0] sel, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!hit && sb_q[i].rd == sel) begin
        hit = 1'b1;
        d   = sb_q[i].data;
      end
    end
    if (!hit && exp_wr_en && exp_sel == sel) begin
      hit = 1'b1;
      d   = exp_data;
    end
    if (sel == 5'd0) begin
      hit = 1'b0;
      d   = 32'd0;
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                       input logic [4:0] fsel);
    alu_valid  = av;
    alu_rd     = ard;
    alu_data   = adat;
    mem_valid  = mv;
    mem_rd     = mrd;
    mem_data   = mdat;
    fwd_select = fsel;
  endtask

  // One clock cycle: check readies, predict acceptance at the edge, check outputs at negedge.
  task automatic step();
    logic        e_ar;
    logic        e_mr;
    logic        e_hit;
    logic [31:0] e_fd;
    ent_t        e;
    #1;
    e_ar = (sb_q.size() < DEPTH);
    e_mr = (sb_q.size() < DEPTH - 1) || (sb_q.size() == DEPTH - 1 && !alu_valid);
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    @(posedge clock);
    exp_wr_en = (sb_q.size() > 0);
    if (alu_valid && e_ar && alu_rd != 5'd0) sb_q.push_back({alu_rd, alu_data});
    if (mem_valid && e_mr && mem_rd != 5'd0) sb_q.push_back({mem_rd, mem_data});
    @(negedge clock);
    check("wr_en", 32'(wr_en), 32'(exp_wr_en));
    if (exp_wr_en) begin
      e = sb_q.pop_front();
      exp_sel  = e.rd;
      exp_data = e.data;
    end
    check("wr_select", 32'(wr_select), 32'(exp_sel));
    check("wr_data", wr_data, exp_data);
    check("count", 32'(count), 32'(sb_q.size()));
    check("pending", pending, model_pending());
    model_fwd(fwd_select, e_hit, e_fd);
    check("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    check("fwd_data", fwd_data, e_fd);
  endtask

  task automatic idle(input int n, input logic [4:0] fsel);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fsel);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state();
    sb_q.delete();
    exp_wr_en = 1'b0;
    exp_sel   = 5'd0;
    exp_data  = 32'd0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_select", 32'(wr_select), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pending", pending, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    @(negedge clock);
    check_reset_state();
    reset_n = 1'b1;

    // single ALU write, then drain and confirm pending clears
    drive(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd0, 32'd0, 5'd5);
    step();
    idle(3, 5'd5);

    // simultaneous writes to the same register: ALU first, load value forwarded
    drive(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'hBBBB0000, 5'd3);
    step();
    idle(3, 5'd3);

    // fill with both sources every cycle, distinct destinations
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(8 + 2 * i), $urandom, 1'b1, 5'(9 + 2 * i), $urandom, 5'(9 + 2 * i));
      step();
    end
    // at occupancy DEPTH-1 a lone load is admitted
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'h30303030, 5'd30);
    step();
    idle(5, 5'd30);

    // x0 writes on both ports with fwd_select = 0
    drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0);
    step();
    idle(2, 5'd0);

    // lookup of a register with no pending write while another is queued
    drive(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 32'd0, 5'd7);
    step();
    idle(3, 5'd7);

    // reset while busy (count=3, wr_en=1) clears everything asynchronously
    drive(1'b1, 5'd20, 32'h20202020, 1'b1, 5'd21, 32'h21212121, 5'd21);
    step();
    drive(1'b1, 5'd22, 32'h22222222, 1'b1, 5'd23, 32'h23232323, 5'd23);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd23);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clock);
    reset_n = 1'b1;
    idle(3, 5'd23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
